uart_tx_serializer: RTL and testbench

UART transmit serializer that sits directly downstream of the baud-rate prescaler. It consumes the prescaler's one-clock-wide baud tick and shifts out parallel words as asynchronous serial frames: start bit, data LSB first, optional parity, stop bits. Words arrive from the host side over a valid/ready handshake. Each bit is held for exactly one full tick period.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_serializer.sv | 155 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings and frame-length helper.
// Used by the transmit serializer and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Number of baud periods from the start bit through the last stop bit.
  function automatic int frame_ticks(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: shifts out start, data (LSB first), optional parity
// and stop bits, advancing one bit per baud_tick from the upstream prescaler.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  import uart_pkg::*;

  localparam int                CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Every output comes straight from a flop so the serial line cannot glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // tx_d is the line value for the bit period that begins after this edge.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          state_d = SYNC;
          shift_d = tx_data;
          par_d   = (PARITY == PAR_ODD) ? ~(^tx_data) : ^tx_data;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end

      // Waiting for a fresh tick keeps the start bit a full period long.
      SYNC: begin
        if (baud_tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != PAR_NONE) begin
              state_d = uart_pkg::PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            tx_d = shift_q[1];
          end
        end
      end

      uart_pkg::PARITY: begin
        if (baud_tick) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations share clock, reset and ticks;
// expected frames are built bit by bit from the word, parity mode and stop count.
module tb_uart_tx_serializer;

  import uart_pkg::*;

  localparam int NDUT = 4;

  int db_cfg  [NDUT] = '{8, 8, 8, 6};
  int par_cfg [NDUT] = '{0, 2, 1, 2};
  int sb_cfg  [NDUT] = '{1, 2, 1, 1};

  logic       clock = 1'b0;
  logic       reset_n;
  logic       baud_tick;
  logic [8:0] data_bus;
  logic       valid [NDUT];
  logic       ready [NDUT];
  logic       tx    [NDUT];
  logic       busy  [NDUT];
  logic       done  [NDUT];

  int   checks = 0;
  int   errors = 0;
  int   period = 16;
  logic exp_bits [$];

  always #5 clock = ~clock;

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(data_bus[7:0]),
    .tx_valid(valid[0]), .tx_ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_8e2 (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(data_bus[7:0]),
    .tx_valid(valid[1]), .tx_ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_8o1 (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(data_bus[7:0]),
    .tx_valid(valid[2]), .tx_ready(ready[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));

  uart_tx_serializer #(.DATA_BITS(6), .PARITY(2), .STOP_BITS(1)) dut_6e1 (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(data_bus[5:0]),
    .tx_valid(valid[3]), .tx_ready(ready[3]), .tx(tx[3]), .busy(busy[3]), .tx_done(done[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, parity from the count of ones, stop 1s.
  task automatic build_frame(input int d, input logic [8:0] w);
    int ones;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < db_cfg[d]; i++) begin
      exp_bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (par_cfg[d] == PAR_EVEN) exp_bits.push_back((ones % 2) == 1);
    if (par_cfg[d] == PAR_ODD)  exp_bits.push_back((ones % 2) == 0);
    for (int s = 0; s < sb_cfg[d]; s++) exp_bits.push_back(1'b1);
  endtask

  task automatic pulse_tick();
    baud_tick = 1'b1;
    @(negedge clock);
    baud_tick = 1'b0;
  endtask

  // Samples n negedges; tx, busy must hold steady and tx_done must stay low.
  task automatic hold_period(input int d, input int n, input logic exp_tx, input logic exp_busy,
                             input string tag);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (tx[d] !== exp_tx || busy[d] !== exp_busy || done[d] !== 1'b0) ok = 1'b0;
      @(negedge clock);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic handshake(input int d, input logic [8:0] w, input bit hold, input bit coincident);
    int guard;
    guard = 0;
    while (ready[d] !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check($sformatf("d%0d_ready_wait", d), 32'(ready[d]), 32'd1);
    data_bus  = w;
    valid[d]  = 1'b1;
    baud_tick = coincident;
    @(negedge clock);
    baud_tick = 1'b0;
    if (!hold) valid[d] = 1'b0;
    check($sformatf("d%0d_accept_busy", d), 32'(busy[d]), 32'd1);
    check($sformatf("d%0d_accept_ready", d), 32'(ready[d]), 32'd0);
    hold_period(d, period - 1, 1'b1, 1'b1, $sformatf("d%0d_sync_idle_line", d));
  endtask

  task automatic run_frame(input int d, input logic [8:0] w);
    int nbits;
    build_frame(d, w);
    nbits = frame_ticks(db_cfg[d], par_cfg[d], sb_cfg[d]);
    pulse_tick();
    for (int k = 0; k < nbits; k++) begin
      hold_period(d, period - 1, exp_bits[k], 1'b1, $sformatf("d%0d_w%0h_bit%0d", d, w, k));
      pulse_tick();
    end
    check($sformatf("d%0d_done_pulse", d), 32'(done[d]), 32'd1);
    check($sformatf("d%0d_done_busy", d), 32'(busy[d]), 32'd0);
    check($sformatf("d%0d_done_ready", d), 32'(ready[d]), 32'd1);
    check($sformatf("d%0d_done_tx", d), 32'(tx[d]), 32'd1);
    @(negedge clock);
    check($sformatf("d%0d_done_width", d), 32'(done[d]), 32'd0);
  endtask

  task automatic check_idle_all(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s_d%0d_tx", tag, d), 32'(tx[d]), 32'd1);
      check($sformatf("%s_d%0d_ready", tag, d), 32'(ready[d]), 32'd1);
      check($sformatf("%s_d%0d_busy", tag, d), 32'(busy[d]), 32'd0);
      check($sformatf("%s_d%0d_done", tag, d), 32'(done[d]), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    baud_tick = 1'b0;
    data_bus  = '0;
    for (int d = 0; d < NDUT; d++) valid[d] = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_all("reset");
    reset_n = 1'b1;

    // Idle with ticks arriving: nothing moves.
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      hold_period(0, 7, 1'b1, 1'b0, "idle_ticks");
    end
    check_idle_all("idle_after_ticks");

    // Asynchronous reset pulse while idle.
    #2 reset_n = 1'b0;
    #1 check_idle_all("reset_mid_idle");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed frames: 8N1 A5, even/odd parity on A5 and 07, 6-bit even parity.
    period = 16;
    handshake(0, 9'h0A5, 1'b0, 1'b0);
    run_frame(0, 9'h0A5);
    handshake(1, 9'h0A5, 1'b0, 1'b0);
    run_frame(1, 9'h0A5);
    handshake(2, 9'h0A5, 1'b0, 1'b0);
    run_frame(2, 9'h0A5);
    handshake(1, 9'h007, 1'b0, 1'b0);
    run_frame(1, 9'h007);
    handshake(3, 9'h02B, 1'b0, 1'b0);
    run_frame(3, 9'h02B);

    // Tick on the handshake edge is ignored; start bit still a full period.
    period = 10;
    handshake(0, 9'h0C6, 1'b0, 1'b1);
    run_frame(0, 9'h0C6);

    // Back-to-back with valid held: second word taken on the tx_done cycle.
    period = 12;
    handshake(1, 9'h055, 1'b1, 1'b0);
    data_bus = 9'h0FF;
    run_frame(1, 9'h055);
    check("b2b_second_accept_ready", 32'(ready[1]), 32'd0);
    check("b2b_second_accept_busy", 32'(busy[1]), 32'd1);
    valid[1] = 1'b0;
    hold_period(1, period - 2, 1'b1, 1'b1, "b2b_sync_line");
    run_frame(1, 9'h0FF);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      hold_period(1, period - 1, 1'b1, 1'b0, "b2b_no_duplicate");
    end

    // Reset during the fourth data bit aborts the frame without tx_done.
    period = 8;
    handshake(0, 9'h0C3, 1'b0, 1'b0);
    build_frame(0, 9'h0C3);
    pulse_tick();
    for (int k = 0; k < 4; k++) begin
      hold_period(0, period - 1, exp_bits[k], 1'b1, $sformatf("abort_bit%0d", k));
      pulse_tick();
    end
    #3 reset_n = 1'b0;
    #1 check_idle_all("reset_mid_data");
    hold_period(0, 12, 1'b1, 1'b0, "reset_hold_no_done");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    handshake(0, 9'h03C, 1'b0, 1'b0);
    run_frame(0, 9'h03C);

    // Randomized frames across all configurations.
    for (int n = 0; n < 16; n++) begin
      int         d;
      logic [8:0] w;
      bit         co;
      d      = int'($urandom_range(0, NDUT - 1));
      w      = 9'($urandom);
      co     = 1'($urandom_range(0, 1));
      period = int'($urandom_range(4, 20));
      handshake(d, w, 1'b0, co);
      run_frame(d, w);
      repeat (int'($urandom_range(0, 5))) @(negedge clock);
    end

    check_idle_all("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
